// File: rtl/digseg_scanner_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Segment patterns are {a,b,c,d,e,f,g} with a as the MSB, active-high.
package digseg_scanner_pkg;

    localparam int NIB_W      = 4;
    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;

    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;

    localparam seg_t SEG_HEX_0 = 7'h7E;
    localparam seg_t SEG_HEX_1 = 7'h30;
    localparam seg_t SEG_HEX_2 = 7'h6D;
    localparam seg_t SEG_HEX_3 = 7'h79;
    localparam seg_t SEG_HEX_4 = 7'h33;
    localparam seg_t SEG_HEX_5 = 7'h5B;
    localparam seg_t SEG_HEX_6 = 7'h5F;
    localparam seg_t SEG_HEX_7 = 7'h70;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h73;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h1F;
    localparam seg_t SEG_HEX_C = 7'h4E;
    localparam seg_t SEG_HEX_D = 7'h3D;
    localparam seg_t SEG_HEX_E = 7'h4F;
    localparam seg_t SEG_HEX_F = 7'h47;

    // A one-digit display still needs a 1-bit index register.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/digseg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module digseg_hex_decode
    import digseg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digseg_scanner.sv
// Time-multiplexed N-digit hex seven-segment scanner with shadow registers.
// Optional leading-zero suppression is built when DIGSEG_LZS_EN is defined.
module digseg_scanner
    import digseg_scanner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     blank_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = idx_width(DIGITS);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_data_reg;
    logic [DIGITS-1:0]   shadow_blank_reg;
    logic [TICK_W-1:0]   tick_reg;
    logic [TICK_W-1:0]   tick_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic                frame_reg;
    logic                frame_next;
    logic [DIGITS-1:0]   an_reg;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_reg;
    logic [6:0]          seg_next;

    logic [3:0]          nibble_arr [DIGITS];
    logic [DIGITS-1:0]   lzs_vec;
    logic [DIGITS-1:0]   dark_vec;
    logic [3:0]          cur_nibble;
    logic                cur_dark;
    logic [6:0]          cur_seg;
    logic                slot_end;

    genvar gi;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble_arr[gi] = shadow_data_reg[gi*4 +: 4];
            assign dark_vec[gi]   = shadow_blank_reg[gi] | lzs_vec[gi];
        end
    endgenerate

`ifdef DIGSEG_LZS_EN
    // upper_zero[k] is set when nibbles k..DIGITS-1 are all zero; digit 0 is never suppressed.
    logic [DIGITS:1] upper_zero;
    assign upper_zero[DIGITS] = 1'b1;
    assign lzs_vec[0]         = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lzs
            assign upper_zero[gi] = (nibble_arr[gi] == 4'h0) && upper_zero[gi+1];
            assign lzs_vec[gi]    = upper_zero[gi];
        end
    endgenerate
`else
    assign lzs_vec = '0;
`endif

    assign cur_nibble = nibble_arr[idx_reg];
    assign cur_dark   = dark_vec[idx_reg];

    digseg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    assign slot_end = (tick_reg == TICK_LAST);

    always_comb begin
        tick_next  = tick_reg + 1'b1;
        idx_next   = idx_reg;
        frame_next = 1'b0;
        if (slot_end) begin
            tick_next = '0;
            if (idx_reg == IDX_LAST) begin
                idx_next   = '0;
                frame_next = 1'b1;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    // Digit enable stays off for the first BLANK_CYC ticks of every slot so the
    // previous digit's segments never ghost onto the newly selected anode.
    always_comb begin
        an_next  = '0;
        seg_next = SEG_BLANK;
        if (!cur_dark) begin
            seg_next = cur_seg;
            if (tick_reg >= TICK_BLANK) begin
                an_next = DIGITS'(1) << idx_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_data_reg  <= '0;
            shadow_blank_reg <= '0;
            tick_reg         <= '0;
            idx_reg          <= '0;
            frame_reg        <= 1'b0;
            an_reg           <= '0;
            seg_reg          <= SEG_BLANK;
        end else begin
            if (load_i) begin
                shadow_data_reg  <= data_i;
                shadow_blank_reg <= blank_i;
            end
            tick_reg  <= tick_next;
            idx_reg   <= idx_next;
            frame_reg <= frame_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
        end
    end

    assign seg_o   = seg_reg;
    assign an_o    = an_reg;
    assign frame_o = frame_reg;

endmodule

// File: tb/tb_digseg_scanner.sv
// Scoreboard bench for digseg_scanner (DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1).
// Build with DIGSEG_LZS_EN defined to exercise leading-zero suppression.
module tb_digseg_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int BLANK_CYC   = 1;

    localparam logic [6:0] TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic        clk;
    logic        rst;
    logic [15:0] data_i;
    logic        load_i;
    logic [3:0]  blank_i;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_o;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t exp_q[$];
    int errors;
    int checks;

    logic [15:0] m_data;
    logic [3:0]  m_blank;
    int          m_tick;
    int          m_idx;

    digseg_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .load_i  (load_i),
        .blank_i (blank_i),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_dark(input int k);
        logic [15:0] upper;
        logic        lzs;
        upper = m_data >> (4 * k);
        lzs   = 1'b0;
`ifdef DIGSEG_LZS_EN
        lzs = (k != 0) && (upper == 16'h0);
`endif
        return m_blank[k] | lzs;
    endfunction

    task automatic model_reset();
        m_data  = 16'h0;
        m_blank = 4'h0;
        m_tick  = 0;
        m_idx   = 0;
        exp_q.delete();
    endtask

    // Predict this edge's registered outputs, advance the model, then compare after the edge.
    task automatic cycle();
        exp_t       e;
        exp_t       got;
        logic [3:0] nib;
        logic       dark;
        nib     = m_data[4*m_idx +: 4];
        dark    = m_dark(m_idx);
        e.an    = (m_tick < BLANK_CYC || dark) ? 4'b0000 : 4'(1 << m_idx);
        e.seg   = dark ? 7'h00 : TBL[nib];
        e.frame = (m_tick == REFRESH_DIV - 1) && (m_idx == DIGITS - 1);
        if (load_i) begin
            m_data  = data_i;
            m_blank = blank_i;
        end
        if (m_tick == REFRESH_DIV - 1) begin
            m_tick = 0;
            m_idx  = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
        end else begin
            m_tick = m_tick + 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (an_o !== got.an) begin
            errors++;
            $display("FAIL sb_an t=%0t: an_o=%b expected %b", $time, an_o, got.an);
        end
        checks++;
        if (seg_o !== got.seg) begin
            errors++;
            $display("FAIL sb_seg t=%0t: seg_o=%h expected %h", $time, seg_o, got.seg);
        end
        checks++;
        if (frame_o !== got.frame) begin
            errors++;
            $display("FAIL sb_frame t=%0t: frame_o=%b expected %b", $time, frame_o, got.frame);
        end
        $display("cycle t=%0t an=%b seg=%h frame=%b", $time, an_o, seg_o, frame_o);
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] b);
        data_i  = d;
        blank_i = b;
        load_i  = 1'b1;
        cycle();
        load_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_i = 16'h0; load_i = 1'b0; blank_i = 4'h0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (an_o !== 4'b0 || seg_o !== 7'h0 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: an=%b seg=%h frame=%b expected all 0", an_o, seg_o, frame_o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (an_o !== 4'b0 || seg_o !== 7'h0 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: an=%b seg=%h frame=%b expected all 0", an_o, seg_o, frame_o);
        end
        rst = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic test_scan_1234();
        int         frames;
        int         shown;
        logic [6:0] want;
        frames = 0;
        shown  = 0;
        load_word(16'h1234, 4'b0000);
        repeat (32) begin
            cycle();
            if (frame_o) frames++;
            if (an_o != 4'b0) begin
                shown++;
                case (an_o)
                    4'b0001: want = 7'h33;
                    4'b0010: want = 7'h79;
                    4'b0100: want = 7'h6D;
                    default: want = 7'h30;
                endcase
                checks++;
                if (seg_o !== want) begin
                    errors++;
                    $display("FAIL scan_1234 an=%b: seg_o=%h expected %h", an_o, seg_o, want);
                end
            end
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL scan_frames: got %0d frame pulses expected 2", frames);
        end
        checks++;
        if (shown != 24) begin
            errors++;
            $display("FAIL scan_shown: got %0d lit cycles expected 24", shown);
        end
    endtask

    task automatic test_blank_abcd();
        logic [6:0] want;
        int         lit2;
        lit2 = 0;
        load_word(16'hABCD, 4'b0100);
        repeat (16) begin
            cycle();
            if (an_o == 4'b0100) lit2++;
            if (an_o != 4'b0 && an_o != 4'b0100) begin
                case (an_o)
                    4'b0001: want = 7'h3D;
                    4'b0010: want = 7'h4E;
                    default: want = 7'h77;
                endcase
                checks++;
                if (seg_o !== want) begin
                    errors++;
                    $display("FAIL blank_abcd an=%b: seg_o=%h expected %h", an_o, seg_o, want);
                end
            end
        end
        checks++;
        if (lit2 != 0) begin
            errors++;
            $display("FAIL blank_digit2: lit %0d cycles expected 0", lit2);
        end
    endtask

    task automatic test_sweep();
        bit found;
        for (int n = 0; n < 16; n++) begin
            load_word({12'h000, 4'(n)}, 4'b0000);
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                cycle();
                if (an_o == 4'b0001) begin
                    found = 1'b1;
                    checks++;
                    if (seg_o !== TBL[n]) begin
                        errors++;
                        $display("FAIL sweep_%0h: seg_o=%h expected %h", n, seg_o, TBL[n]);
                    end
                end
            end
            if (!found) begin
                errors++;
                checks++;
                $display("FAIL sweep_timeout_%0h: digit0 never selected expected within 20 cycles", n);
            end
        end
    endtask

    task automatic test_hold();
        load_word(16'h5A3C, 4'b0000);
        for (int c = 0; c < 16; c++) begin
            data_i  = 16'($urandom);
            blank_i = 4'($urandom);
            cycle();
        end
    endtask

    task automatic test_midslot_load();
        int guard;
        load_word(16'h1234, 4'b0000);
        guard = 0;
        while (!(m_idx == 0 && m_tick == 1) && guard < 20) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL midslot_align: slot not reached in %0d cycles expected < 20", guard);
        end
        data_i = 16'h1239;
        load_i = 1'b1;
        cycle();
        load_i = 1'b0;
        checks++;
        if (seg_o !== 7'h33) begin
            errors++;
            $display("FAIL midslot_old: seg_o=%h expected 33", seg_o);
        end
        cycle();
        checks++;
        if (seg_o !== 7'h73 || an_o !== 4'b0001) begin
            errors++;
            $display("FAIL midslot_new: seg_o=%h an_o=%b expected 73/0001", seg_o, an_o);
        end
        repeat (6) cycle();
    endtask

    task automatic test_back_to_back();
        load_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            data_i  = 16'($urandom);
            blank_i = 4'($urandom_range(0, 15));
            cycle();
        end
        load_i = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_reset_midscan();
        int guard;
        int wait_cyc;
        load_word(16'h9876, 4'b0000);
        guard = 0;
        while (!(m_idx == 2 && m_tick == 2) && guard < 20) begin
            cycle();
            guard++;
        end
        cycle();
        #3 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (an_o !== 4'b0 || seg_o !== 7'h0 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: an=%b seg=%h frame=%b expected all 0", an_o, seg_o, frame_o);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        wait_cyc = 0;
        while (an_o == 4'b0 && wait_cyc < 8) begin
            cycle();
            wait_cyc++;
        end
        checks++;
        if (an_o !== 4'b0001 || wait_cyc != 2) begin
            errors++;
            $display("FAIL reset_restart: an_o=%b after %0d cycles expected 0001 after 2", an_o, wait_cyc);
        end
    endtask

`ifdef DIGSEG_LZS_EN
    task automatic test_lzs();
        logic [6:0] want;
        bit         bad;
        load_word(16'h0040, 4'b0000);
        repeat (16) begin
            cycle();
            if (an_o != 4'b0) begin
                bad  = (an_o != 4'b0001) && (an_o != 4'b0010);
                want = (an_o == 4'b0010) ? 7'h33 : 7'h7E;
                checks++;
                if (bad || seg_o !== want) begin
                    errors++;
                    $display("FAIL lzs_0040 an=%b: seg_o=%h expected digit0 7E or digit1 33", an_o, seg_o);
                end
            end
        end
        load_word(16'h0000, 4'b0000);
        repeat (16) begin
            cycle();
            if (an_o != 4'b0) begin
                checks++;
                if (an_o !== 4'b0001 || seg_o !== 7'h7E) begin
                    errors++;
                    $display("FAIL lzs_0000 an=%b seg=%h expected only 0001/7E", an_o, seg_o);
                end
            end
        end
    endtask
`else
    task automatic test_zeros_shown();
        logic [3:0] seen;
        seen = 4'b0;
        load_word(16'h0000, 4'b0000);
        repeat (16) begin
            cycle();
            seen = seen | an_o;
            if (an_o != 4'b0) begin
                checks++;
                if (seg_o !== 7'h7E) begin
                    errors++;
                    $display("FAIL zeros_seg an=%b: seg_o=%h expected 7E", an_o, seg_o);
                end
            end
        end
        checks++;
        if (seen !== 4'b1111) begin
            errors++;
            $display("FAIL zeros_digits: lit mask %b expected 1111", seen);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_scan_1234();
        test_blank_abcd();
        test_sweep();
        test_hold();
        test_midslot_load();
        test_back_to_back();
        test_reset_midscan();
`ifdef DIGSEG_LZS_EN
        test_lzs();
`else
        test_zeros_shown();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
